// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default payload width
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - TX frame sequencer: state, bit counter, acceptance and Busy
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        data_valid,
  input  logic        par_en,
  output logic        accept,
  output uart_state_e state,
  output logic        Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_e      next_state;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;

  assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

  // State register; Busy follows the state by one cycle so it lines up with the registered line
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      Busy  <= 1'b0;
    end else begin
      state <= next_state;
      Busy  <= (state != IDLE);
    end
  end

  // Data bit counter: runs only in DATA and wraps to 0 on the last payload bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt <= '0;
    end else if (state == DATA && !last_bit) begin
      bit_cnt <= bit_cnt + 1'b1;
    end else begin
      bit_cnt <= '0;
    end
  end

  // Next-state logic; a new byte is taken only while idle or sending the stop bit
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        accept = data_valid;
        if (data_valid) next_state = START;
      end
      START:  next_state = DATA;
      DATA: begin
        if (last_bit) next_state = par_en ? PARITY : STOP;
      end
      PARITY: next_state = STOP;
      STOP: begin
        accept     = data_valid;
        next_state = data_valid ? START : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: shift register, parity, output mux and line flop
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  uart_state_e           state;
  logic                  accept;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  tx_d;

  uart_tx_fsm #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fsm (
    .CLK        (CLK),
    .RST        (RST),
    .data_valid (DATA_VALID),
    .par_en     (par_en_q),
    .accept     (accept),
    .state      (state),
    .Busy       (Busy)
  );

  // Capture byte and parity config at acceptance; shift one bit out per DATA cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (accept) begin
      shift_q   <= P_DATA;
      par_en_q  <= PAR_EN;
      par_bit_q <= PAR_TYP ? ~^P_DATA : ^P_DATA;
    end else if (state == DATA) begin
      shift_q   <= shift_q >> 1;
    end
  end

  // Line value for the current state; registered below so the line never glitches
  always_comb begin
    tx_d = 1'b1;
    case (state)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = par_bit_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // Output flop; reset forces the line back to the idle level at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TX_OUT <= 1'b1;
    end else begin
      TX_OUT <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized scoreboard bench for uart_tx
module tb_uart_tx;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  // Each entry is {expected TX_OUT, expected Busy} for one line cycle
  logic [1:0] exp_q[$];
  logic [1:0] exp_e;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void check(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0b required %0b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference frame: start, payload LSB first, optional parity making the total
  // count of ones even (even) or odd (odd), then stop. When the line is idle the
  // byte shows up one extra cycle later, with Busy still low in that cycle.
  function automatic void push_frame(logic [7:0] d, logic pe, logic pt);
    int  ones;
    logic par;
    ones = $countones(d);
    par  = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
    if (exp_q.size() == 0) exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 1'b1});
    if (pe) exp_q.push_back({par, 1'b1});
    exp_q.push_back(2'b11);
  endfunction

  // Monitor: compares the line against the scoreboard every cycle
  always @(negedge CLK) begin
    if (mon_en) begin
      if (RST) begin
        exp_q.delete();
        check("reset_tx", TX_OUT, 1'b1);
        check("reset_busy", Busy, 1'b0);
      end else if (exp_q.size() == 0) begin
        check("idle_tx", TX_OUT, 1'b1);
        check("idle_busy", Busy, 1'b0);
      end else begin
        exp_e = exp_q.pop_front();
        check("line_tx", TX_OUT, exp_e[1]);
        check("line_busy", Busy, exp_e[0]);
      end
    end
  end

  // One stimulus cycle; the model decides acceptance from what is still pending
  task automatic drive(input logic dv, input logic [7:0] d, input logic pe, input logic pt);
    @(negedge CLK);
    #1;
    DATA_VALID = dv;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    if (dv && !RST && exp_q.size() <= 1) push_frame(d, pe, pt);
  endtask

  task automatic drive_noise();
    drive(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      drive_noise();
      n++;
    end
    check_int("wait_idle_pending", exp_q.size(), 0);
  endtask

  initial begin
    RST        = 1'b1;
    DATA_VALID = 1'b0;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    repeat (3) @(negedge CLK);
    mon_en = 1;
    @(negedge CLK);
    #2 RST = 1'b0;

    // Idle with no strobes
    repeat (12) drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Directed frames
    drive(1'b1, 8'hA5, 1'b0, 1'b0); wait_idle();
    drive(1'b1, 8'hA5, 1'b1, 1'b0); wait_idle();
    drive(1'b1, 8'hA5, 1'b1, 1'b1); wait_idle();
    drive(1'b1, 8'h00, 1'b1, 1'b1); wait_idle();

    // Back-to-back with an ignored strobe during DATA
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    repeat (4) drive_noise();
    drive(1'b1, 8'h5A, 1'b1, 1'b1);
    begin
      int n;
      n = 0;
      while (exp_q.size() != 1 && n < 20) begin
        drive_noise();
        n++;
      end
      check_int("b2b_stop_reached", exp_q.size(), 1);
    end
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    wait_idle();

    // Randomized traffic with mid-frame input churn
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_idle();

    // Reset while data bit 4 is on the line
    drive(1'b1, 8'hC6, 1'b1, 1'b0);
    repeat (7) drive_noise();
    #1 RST = 1'b1;
    exp_q.delete();
    #1;
    check("async_reset_tx", TX_OUT, 1'b1);
    check("async_reset_busy", Busy, 1'b0);
    repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge CLK);
    #2 RST = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h81, 1'b1, 1'b0);
    wait_idle();
    repeat (3) drive_noise();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: the transmit end of the system UART, paired with the existing receiver. Accepts a parallel byte with a single-cycle valid strobe and serialises it as start bit, data LSB-first, an optional even/odd parity bit, and a stop bit. Runs on the UART TX clock at one clock per bit, with no oversampling. Contains the TX FSM, serializer, parity calculator and output mux.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame.
- `CLK` input 1: TX bit clock; one bit period per cycle.
- `RST` input 1: asynchronous, active-high reset.
- `P_DATA` input DATA_WIDTH: parallel byte to send; sampled only on acceptance.
- `DATA_VALID` input 1: single-cycle strobe; `P_DATA` is valid this cycle.
- `PAR_EN` input 1: 1 inserts a parity bit; sampled on acceptance.
- `PAR_TYP` input 1: 0 selects even parity, 1 selects odd; sampled on acceptance.
- `TX_OUT` output 1: serial line, registered, idles at 1.
- `Busy` output 1: registered; 1 from the start bit through the stop bit.

## Operation
- FSM states:
  - IDLE: `TX_OUT`=1, `Busy`=0.
  - START: `TX_OUT`=0.
  - DATA: shift out `P_DATA[0]` first.
  - PARITY: `TX_OUT`=parity bit.
  - STOP: `TX_OUT`=1.
- Acceptance occurs when `DATA_VALID`=1 while the state is IDLE or STOP. On acceptance:
  - latch `P_DATA` into the shift register;
  - latch `PAR_EN` and `PAR_TYP`;
  - compute the parity bit: `^P_DATA` for even, `~^P_DATA` for odd.
- `DATA_VALID` in START, DATA or PARITY is ignored. There is no queueing.
- State transitions:
  - IDLE goes to START on acceptance.
  - START goes to DATA after 1 cycle.
  - DATA runs for exactly DATA_WIDTH cycles, counted by a bit counter of width clog2(DATA_WIDTH). On the last data bit it goes to PARITY if the latched `PAR_EN`=1, else to STOP.
  - PARITY goes to STOP after 1 cycle.
  - STOP goes to START if there is acceptance in that cycle (back-to-back frames, no idle gap), else to IDLE.
- Input changes mid-frame on `P_DATA`, `PAR_EN` or `PAR_TYP` have no effect on the frame in flight.
- `DATA_VALID` held high continuously causes a re-accept at every STOP cycle. Upstream issues one pulse per byte, gated by `Busy`=0 or by its own stop-bit tracking.
- Reset:
  - values: `TX_OUT`=1, `Busy`=0, state=IDLE, bit counter=0, shift register=0, latched parity config=0.
  - Reset asserted mid-frame aborts the frame immediately (asynchronously). The line returns to 1.

## Timing
- Acceptance at edge N: `TX_OUT`=0 and `Busy`=1 from edge N+1 (registered, 1-cycle latency).
- Frame length: 10 cycles with `PAR_EN`=0, 11 with `PAR_EN`=1 (DATA_WIDTH=8).
- Data bit k appears on `TX_OUT` during cycle N+2+k.
- Parity, if enabled, appears at cycle N+2+DATA_WIDTH. Stop follows it.
- `Busy` falls at the edge after STOP only if there was no acceptance in STOP. With back-to-back acceptance, `Busy` stays 1 across frames.
- `TX_OUT` is driven directly from a flop, so the line never glitches.

## Structure
- Shared package `uart_pkg`: the state encoding localparams (IDLE, START, DATA, PARITY, STOP; 3-bit) and the default DATA_WIDTH. The receiver uses the same package for width.
- Sub-module `uart_tx_fsm`: state register, bit counter, next-state logic, and the mux select/`Busy` outputs.
- Top level `uart_tx`: shift register, parity calc, output mux and the `TX_OUT` register.

## Test plan
- Reset then idle, no `DATA_VALID`: `TX_OUT`=1 and `Busy`=0 indefinitely.
- `P_DATA`=0xA5, `PAR_EN`=0:
  - `TX_OUT` = 0,1,0,1,0,0,1,0,1,1 over 10 cycles;
  - `Busy` high for exactly 10 cycles, starting 1 cycle after the strobe.
- `P_DATA`=0xA5 with `PAR_EN`=1 → parity bit 0 for `PAR_TYP`=0 and 1 for `PAR_TYP`=1. `P_DATA`=0x00 with `PAR_EN`=1, `PAR_TYP`=1 → parity bit 1. All frames are 11 cycles.
- Back-to-back: 0x3C accepted, then `DATA_VALID` with 0xFF in the STOP cycle:
  - the second start bit follows the stop bit directly;
  - `Busy` never drops;
  - a `DATA_VALID` pulse during the DATA state is ignored.
- Mid-frame changes: `P_DATA`, `PAR_EN` and `PAR_TYP` toggled during DATA → transmitted bits and parity match the values latched at acceptance.
- `RST` asserted during data bit 4 → `TX_OUT`=1 and `Busy`=0 immediately. After release, a new 0x81 frame transmits correctly.
